// File: rtl/demux2_16b_hs.sv
// demux2_16b_hs: registered 1-to-2 valid/ready steering with per-destination delivered-word counters
// Ports: clk, reset (sync, active-high); in_valid/in_data/in_sel/in_ready producer side;
//        a_valid/a_data/a_ready and b_valid/b_data/b_ready consumer sides; a_count/b_count delivered words.
module demux2_16b_hs #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);
  logic             r_a_valid, r_b_valid;
  logic [WIDTH-1:0] r_a_data, r_b_data;
  logic [CNT_W-1:0] r_a_count, r_b_count;
  logic             w_free_a, w_free_b, w_acc_a, w_acc_b, w_hs_a, w_hs_b;
  // a register is free when empty or being drained this cycle, allowing back-to-back reloads
  assign w_free_a = !r_a_valid || a_ready;
  assign w_free_b = !r_b_valid || b_ready;
  assign in_ready = !reset && (in_sel ? w_free_b : w_free_a);
  assign w_acc_a  = in_valid && in_ready && !in_sel;
  assign w_acc_b  = in_valid && in_ready && in_sel;
  assign w_hs_a   = r_a_valid && a_ready;
  assign w_hs_b   = r_b_valid && b_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_acc_a) r_a_data <= in_data;
      if (w_acc_b) r_b_data <= in_data;
      r_a_valid <= w_acc_a || (r_a_valid && !a_ready);
      r_b_valid <= w_acc_b || (r_b_valid && !b_ready);
      if (w_hs_a) r_a_count <= r_a_count + 1'b1;
      if (w_hs_b) r_b_count <= r_b_count + 1'b1;
    end
  end
  assign a_valid = r_a_valid;
  assign b_valid = r_b_valid;
  assign a_data  = r_a_data;
  assign b_data  = r_b_data;
  assign a_count = r_a_count;
  assign b_count = r_b_count;
endmodule

// File: tb/tb_demux2_16b_hs.sv
// tb_demux2_16b_hs: scoreboard bench for demux2_16b_hs
module tb_demux2_16b_hs;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_sel = 0, in_ready;
  logic [15:0] in_data = 0;
  logic        a_valid, b_valid, a_ready = 0, b_ready = 0;
  logic [15:0] a_data, b_data;
  logic [7:0]  a_count, b_count;
  logic [15:0] qa[$], qb[$];
  int          n_cmp = 0, n_bad = 0;

  demux2_16b_hs dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(in_ready), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected: got 0x%0h expected no word", a_data);
        end else chk("a_data", a_data, qa.pop_front());
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: got 0x%0h expected no word", b_data);
        end else chk("b_data", b_data, qb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    bit ok = 0;
    in_valid = 1; in_data = d; in_sel = s;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (s) qb.push_back(d); else qa.push_back(d);
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: word 0x%0h never accepted, expected acceptance", d);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    // reset then idle
    in_valid = 1; in_data = 16'hDEAD;
    @(negedge clk); in_sel = 0; #1 chk("rst_ready_a", in_ready, 0);
    in_sel = 1; #1 chk("rst_ready_b", in_ready, 0);
    idle(2);
    reset = 0; in_valid = 0;
    @(negedge clk);
    chk("idle_a_valid", a_valid, 0); chk("idle_b_valid", b_valid, 0);
    chk("idle_a_data", a_data, 0);   chk("idle_b_data", b_data, 0);
    chk("idle_a_count", a_count, 0); chk("idle_b_count", b_count, 0);
    in_sel = 0; #1 chk("idle_ready_a", in_ready, 1);
    in_sel = 1; #1 chk("idle_ready_b", in_ready, 1);
    idle(1);
    // basic steer
    a_ready = 1; b_ready = 1;
    send(16'h1234, 0);
    @(negedge clk); chk("lat_a_valid", a_valid, 1); chk("lat_a_data", a_data, 16'h1234);
    idle(1);
    send(16'hABCD, 1);
    send(16'h00FF, 0);
    idle(2);
    chk("steer_a_count", a_count, 2); chk("steer_b_count", b_count, 1);
    // stall and independence
    a_ready = 0;
    send(16'h1111, 0);
    in_valid = 1; in_data = 16'h2222; in_sel = 0;
    @(negedge clk);
    chk("stall_ready", in_ready, 0); chk("stall_a_valid", a_valid, 1); chk("stall_a_data", a_data, 16'h1111);
    idle(1);
    send(16'h3333, 1);
    idle(1);
    chk("stall_hold", a_data, 16'h1111); chk("stall_b_count", b_count, 2);
    in_valid = 1; in_data = 16'h2222; in_sel = 0;
    @(negedge clk); chk("stall_ready2", in_ready, 0);
    @(posedge clk); #1;
    a_ready = 1;
    send(16'h2222, 0);
    idle(2);
    chk("stall_a_count", a_count, 4);
    // full throughput
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 16'(i); in_sel = 0;
      @(negedge clk);
      chk("tp_ready", in_ready, 1);
      if (i > 0) chk("tp_no_bubble", a_valid, 1);
      qa.push_back(16'(i));
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk); chk("tp_last_valid", a_valid, 1);
    @(negedge clk); chk("tp_drained", a_valid, 0);
    chk("tp_a_count", a_count, 14);
    idle(1);
    // counter wrap on B
    for (int i = 0; i < 257; i++) send(16'(16'h4000 + i), 1);
    idle(2);
    chk("wrap_b_count", b_count, 3); chk("wrap_a_count", a_count, 14);
    // reset mid-operation
    a_ready = 0; b_ready = 0;
    send(16'h5A5A, 0);
    send(16'hB0B0, 1);
    @(negedge clk);
    chk("pre_rst_a_valid", a_valid, 1); chk("pre_rst_b_valid", b_valid, 1); chk("pre_rst_a_data", a_data, 16'h5A5A);
    @(posedge clk); #1;
    reset = 1; a_ready = 1; b_ready = 1;
    qa.delete(); qb.delete();
    @(negedge clk); chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_a_valid", a_valid, 0); chk("post_rst_b_valid", b_valid, 0);
    chk("post_rst_a_data", a_data, 0);   chk("post_rst_b_data", b_data, 0);
    chk("post_rst_a_count", a_count, 0); chk("post_rst_b_count", b_count, 0);
    idle(1);
    send(16'h0F0F, 0);
    idle(2);
    chk("resume_a_count", a_count, 1); chk("resume_b_count", b_count, 0);
    chk("qa_empty", qa.size(), 0); chk("qb_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux2_16b_hs.md
Name: demux2_16b_hs

Overview:
Registered 1-to-2 steering block, the dispatch counterpart to the datapath 2:1 selectors. It takes one 16-bit word stream with a valid/ready handshake and a per-word select. Each word goes to destination A (sel=0) or destination B (sel=1) through a one-entry holding register per destination. Used where a single producer, such as ALU or memory writeback, must feed one of two consumers that can stall independently. Per-destination delivered-word counters support debug and verification.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 8, width of each delivered-word counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data/in_sel
in_data  input  WIDTH  word to steer
in_sel  input  1  destination select: 0 -> A, 1 -> B
in_ready  output  1  block accepts the word this cycle (combinational)
a_valid  output  1  holding register A occupied
a_data  output  WIDTH  word held for destination A
a_ready  input  1  destination A consumes a_data this cycle
b_valid  output  1  holding register B occupied
b_data  output  WIDTH  word held for destination B
b_ready  input  1  destination B consumes b_data this cycle
a_count  output  CNT_W  number of words delivered on A, modulo 2^CNT_W
b_count  output  CNT_W  number of words delivered on B, modulo 2^CNT_W

Behaviour:
- Reset (sampled at clk edge while reset=1): a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0. While reset=1, in_ready=0 regardless of other inputs. Held words are discarded; a reset mid-stall loses them with no delivery and no count.
- Destination free condition: freeA = !a_valid || a_ready; freeB = !b_valid || b_ready.
- in_ready = !reset && (in_sel ? freeB : freeA). in_ready depends only on in_sel, the target's state and the target's ready. It never depends on in_valid.
- Accept = in_valid && in_ready. On accept with in_sel=0: a_data <= in_data and a_valid <= 1 at the next edge. in_sel=1 works the same way for B. Latency is one cycle from accept to valid at the output.
- Output handshake A = a_valid && a_ready, and likewise for B. On handshake without a new accept to the same destination, valid clears at the next edge.
- Simultaneous handshake and accept to the same destination: the register reloads and valid stays 1. This gives one word per cycle per destination with no bubble.
- Stall: while a_valid=1 and a_ready=0, a_data holds stable. A word with in_sel=0 then sees in_ready=0. B is unaffected, so a word with in_sel=1 is accepted if freeB.
- Head-of-line: a stalled word for A blocks the input stream. There is no reordering or buffering beyond one word per destination.
- No ordering guarantee between A and B. Order within each destination is preserved.
- in_data and in_sel are ignored when in_valid=0. The data registers change only on accept.
- Counters: a_count increments by 1 on each A handshake and wraps from 2^CNT_W-1 to 0. b_count behaves the same way. Both counters are registered, so the value updates at the edge that completes the handshake.
- A ready asserted while valid=0 has no effect and is not counted.

Test Plan:
- Reset then idle: hold reset 2 cycles, then release with in_valid=0 -> all valids 0, data 0, counts 0; in_ready=0 during reset and 1 after it for either in_sel.
- Basic steer: a_ready=b_ready=1; send 0x1234 (sel=0), then 0xABCD (sel=1), then 0x00FF (sel=0) -> 0x1234 on A at cycle+1, 0xABCD on B at cycle+2, 0x00FF on A at cycle+3; a_count=2, b_count=1.
- Stall and independence: a_ready=0; send 0x1111 to A -> a_valid=1, a_data=0x1111 held. Next word 0x2222 to A sees in_ready=0 and waits; a word 0x3333 sent to B meanwhile -> accepted and delivered. Raise a_ready -> 0x1111 delivered, then 0x2222 the next cycle.
- Full throughput: a_ready=1, in_valid=1, sel=0 for 10 consecutive cycles with data 0..9 -> a_valid stays high for 10 cycles with no bubble, a_data=0..9 in order, a_count=10.
- Counter wrap, CNT_W=8: deliver 257 words to B -> b_count=1, a_count unchanged.
- Reset mid-operation: with a_valid=1 stalled at 0x5A5A and b_valid=1, assert reset 1 cycle -> both valids 0, data 0, counts 0, nothing delivered; normal operation resumes afterwards.
